// File: rtl/exe_wb_buf.sv
// exe_wb_buf: per-execution-unit writeback queue in front of the CDB arbiter.
// Finished results are queued in a small FIFO. wb_req_ is raised while the
// queue holds anything, and a grant pops the head into a registered
// writeback bundle that is valid for exactly one cycle.
// Optional feature macro: WB_BUF_BYPASS_EN. When it is defined, a result that
// arrives at an empty queue requests in the same cycle and, if granted, skips
// the FIFO.
module exe_wb_buf #(
    parameter int DATA  = 32,
    parameter int DEPTH = 4,
    parameter int RD_W  = 5,
    parameter int EXP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_,
    input  logic             in_e_,
    input  logic [RD_W-1:0]  in_rd,
    input  logic [DATA-1:0]  in_data,
    input  logic             in_exp_,
    input  logic [EXP_W-1:0] in_exp_code,
    output logic             busy,
    output logic [$clog2(DEPTH):0] count,
    output logic             wb_req_,
    input  logic             wb_ack_,
    output logic [RD_W-1:0]  pre_wb_rd,
    output logic             wb_e_,
    output logic [RD_W-1:0]  wb_rd,
    output logic [DATA-1:0]  wb_data,
    output logic             wb_exp_,
    output logic [EXP_W-1:0] wb_exp_code
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]    FULL_CNT         = CW'(DEPTH);
    // Instruction-address-misaligned code; doubles as the idle code on the bus.
    localparam logic [EXP_W-1:0] EXP_I_MISS_ALIGN = '0;

    logic [RD_W-1:0]  r_mem_rd   [DEPTH];
    logic [DATA-1:0]  r_mem_data [DEPTH];
    logic             r_mem_exp  [DEPTH];
    logic [EXP_W-1:0] r_mem_code [DEPTH];

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic             r_wb_e;
    logic [RD_W-1:0]  r_wb_rd;
    logic [DATA-1:0]  r_wb_data;
    logic             r_wb_exp;
    logic [EXP_W-1:0] r_wb_code;

    logic w_empty;
    logic w_full;
    logic w_byp;
    logic w_req;
    logic w_pop;
    logic w_pop_fifo;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);

`ifdef WB_BUF_BYPASS_EN
    // A flush suppresses the bypass request so nothing flushed reaches the bus.
    assign w_byp = w_empty & ~in_e_ & flush_;
`else
    assign w_byp = 1'b0;
`endif

    assign w_req      = ~w_empty | w_byp;
    assign w_pop      = w_req & ~wb_ack_;
    assign w_pop_fifo = w_pop & ~w_empty;
    // A granted bypass result goes straight to the output register instead.
    // The full check drops an illegal push without disturbing the queue.
    assign w_push     = ~in_e_ & flush_ & ~w_full & ~(w_byp & ~wb_ack_);

    assign wb_req_   = ~w_req;
    assign busy      = w_full;
    assign count     = r_count;
    assign pre_wb_rd = !w_empty ? r_mem_rd[r_head] : (w_byp ? in_rd : '0);

    assign wb_e_       = r_wb_e;
    assign wb_rd       = r_wb_rd;
    assign wb_data     = r_wb_data;
    assign wb_exp_     = r_wb_exp;
    assign wb_exp_code = r_wb_code;

    // Storage: write the incoming result at the tail (data only, no reset).
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_tail]   <= in_rd;
            r_mem_data[r_tail] <= in_data;
            r_mem_exp[r_tail]  <= in_exp_;
            r_mem_code[r_tail] <= in_exp_code;
        end
    end

    // Pointers and occupancy; flush empties the queue and drops the push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (!flush_) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)     r_tail <= r_tail + PW'(1);
            if (w_pop_fifo) r_head <= r_head + PW'(1);
            case ({w_push, w_pop_fifo})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Writeback register: one-cycle pulse after a pop, idle values otherwise.
    // A pop granted during a flush still completes, since pre_wb_rd was
    // already broadcast by the arbiter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb_e    <= 1'b1;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
            r_wb_exp  <= 1'b1;
            r_wb_code <= EXP_I_MISS_ALIGN;
        end else if (w_pop_fifo) begin
            r_wb_e    <= 1'b0;
            r_wb_rd   <= r_mem_rd[r_head];
            r_wb_data <= r_mem_data[r_head];
            r_wb_exp  <= r_mem_exp[r_head];
            r_wb_code <= r_mem_code[r_head];
        end else if (w_pop) begin
            r_wb_e    <= 1'b0;
            r_wb_rd   <= in_rd;
            r_wb_data <= in_data;
            r_wb_exp  <= in_exp_;
            r_wb_code <= in_exp_code;
        end else begin
            r_wb_e    <= 1'b1;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
            r_wb_exp  <= 1'b1;
            r_wb_code <= EXP_I_MISS_ALIGN;
        end
    end

endmodule

// File: tb/tb_exe_wb_buf.sv
// Directed testbench for exe_wb_buf (DEPTH=4, DATA=32, 5-bit rd, 4-bit code).
// Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_exe_wb_buf;
    localparam int DATA  = 32;
    localparam int DEPTH = 4;
    localparam int RD_W  = 5;
    localparam int EXP_W = 4;
    localparam logic [EXP_W-1:0] MISS = 4'h0;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush_;
    logic             in_e_;
    logic [RD_W-1:0]  in_rd;
    logic [DATA-1:0]  in_data;
    logic             in_exp_;
    logic [EXP_W-1:0] in_exp_code;
    logic             busy;
    logic [2:0]       count;
    logic             wb_req_;
    logic             wb_ack_;
    logic [RD_W-1:0]  pre_wb_rd;
    logic             wb_e_;
    logic [RD_W-1:0]  wb_rd;
    logic [DATA-1:0]  wb_data;
    logic             wb_exp_;
    logic [EXP_W-1:0] wb_exp_code;

    int n_tot = 0;
    int n_bad = 0;

    exe_wb_buf #(.DATA(DATA), .DEPTH(DEPTH), .RD_W(RD_W), .EXP_W(EXP_W)) dut (
        .clk(clk), .reset(reset), .flush_(flush_),
        .in_e_(in_e_), .in_rd(in_rd), .in_data(in_data),
        .in_exp_(in_exp_), .in_exp_code(in_exp_code),
        .busy(busy), .count(count), .wb_req_(wb_req_), .wb_ack_(wb_ack_),
        .pre_wb_rd(pre_wb_rd), .wb_e_(wb_e_), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_exp_(wb_exp_), .wb_exp_code(wb_exp_code)
    );

    always #5 clk = ~clk;

    // A unit must never push into a full queue.
    always @(negedge clk) begin
        if (!reset && flush_)
            assert (!(busy && !in_e_)) else $error("push while busy");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tot++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [RD_W-1:0] rd, input logic [DATA-1:0] d,
                        input logic ex, input logic [EXP_W-1:0] code);
        in_e_ = 1'b0; in_rd = rd; in_data = d; in_exp_ = ex; in_exp_code = code;
    endtask

    task automatic idle();
        in_e_ = 1'b1; in_rd = '0; in_data = '0; in_exp_ = 1'b1; in_exp_code = '0;
    endtask

    task automatic chk_idle_out(input string tag);
        chk({tag, ".wb_e_"}, 32'(wb_e_), 32'd1);
        chk({tag, ".wb_rd"}, 32'(wb_rd), 32'd0);
        chk({tag, ".wb_data"}, wb_data, 32'd0);
        chk({tag, ".wb_exp_"}, 32'(wb_exp_), 32'd1);
        chk({tag, ".code"}, 32'(wb_exp_code), 32'(MISS));
    endtask

    initial begin
        reset = 1'b1; flush_ = 1'b1; wb_ack_ = 1'b1;
        idle();
        tick(); tick();
        reset = 1'b0;
        #1;
        // Reset state
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.req", 32'(wb_req_), 32'd1);
        chk("rst.pre", 32'(pre_wb_rd), 32'd0);
        chk_idle_out("rst");
        tick();

        // Single result, grant tied low
        wb_ack_ = 1'b0;
        push(5'd5, 32'h1234, 1'b1, 4'h3);
        #1;
`ifdef WB_BUF_BYPASS_EN
        chk("t1.req_c0", 32'(wb_req_), 32'd0);
        chk("t1.pre_c0", 32'(pre_wb_rd), 32'd5);
        tick(); idle(); #1;
`else
        chk("t1.req_c0", 32'(wb_req_), 32'd1);
        tick(); idle(); #1;
        chk("t1.req_c1", 32'(wb_req_), 32'd0);
        chk("t1.pre_c1", 32'(pre_wb_rd), 32'd5);
        chk("t1.wbe_c1", 32'(wb_e_), 32'd1);
        tick();
`endif
        chk("t1.wbe", 32'(wb_e_), 32'd0);
        chk("t1.wbrd", 32'(wb_rd), 32'd5);
        chk("t1.wbdata", wb_data, 32'h1234);
        chk("t1.count", 32'(count), 32'd0);
        chk("t1.req_after", 32'(wb_req_), 32'd1);
        tick();
        chk_idle_out("t1.after");

        // Fill and drain with grant withheld
        wb_ack_ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(5'(i + 1), 32'hA1 + 32'(i), 1'b1, 4'h2);
            tick();
        end
        idle(); #1;
        chk("t2.count", 32'(count), 32'd4);
        chk("t2.busy", 32'(busy), 32'd1);
        chk("t2.pre", 32'(pre_wb_rd), 32'd1);
        chk("t2.req", 32'(wb_req_), 32'd0);
        chk("t2.wbe_held", 32'(wb_e_), 32'd1);
        wb_ack_ = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2.drain.wbe", 32'(wb_e_), 32'd0);
            chk("t2.drain.rd", 32'(wb_rd), 32'(i + 1));
            chk("t2.drain.data", wb_data, 32'hA1 + 32'(i));
        end
        chk("t2.count_end", 32'(count), 32'd0);
        chk("t2.busy_end", 32'(busy), 32'd0);
        wb_ack_ = 1'b1;
        tick();
        chk("t2.wbe_end", 32'(wb_e_), 32'd1);

        // Simultaneous push/pop at count=2, across a pointer wrap
        push(5'd10, 32'hB10, 1'b1, 4'h1); tick();
        push(5'd11, 32'hB11, 1'b1, 4'h1); tick();
        chk("t3.count2", 32'(count), 32'd2);
        wb_ack_ = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push(5'(12 + k), 32'hB12 + 32'(k), 1'b1, 4'h1);
            tick();
            chk("t3.count", 32'(count), 32'd2);
            chk("t3.wbe", 32'(wb_e_), 32'd0);
            chk("t3.rd", 32'(wb_rd), 32'(10 + k));
            chk("t3.data", wb_data, 32'hB10 + 32'(k));
        end
        idle();
        tick();
        chk("t3.rd14", 32'(wb_rd), 32'd14);
        chk("t3.cnt1", 32'(count), 32'd1);
        tick();
        chk("t3.rd15", 32'(wb_rd), 32'd15);
        chk("t3.data15", wb_data, 32'hB15);
        chk("t3.cnt0", 32'(count), 32'd0);
        wb_ack_ = 1'b1;
        tick();

        // Flush with a grant in the same cycle at count=3
        for (int i = 0; i < 3; i++) begin
            push(5'(20 + i), 32'hC20 + 32'(i), 1'b1, 4'h6);
            tick();
        end
        push(5'd23, 32'hC23, 1'b1, 4'h6);
        #1;
        chk("t4.count3", 32'(count), 32'd3);
        chk("t4.pre", 32'(pre_wb_rd), 32'd20);
        flush_ = 1'b0; wb_ack_ = 1'b0;
        tick();
        flush_ = 1'b1; wb_ack_ = 1'b1; idle(); #1;
        chk("t4.wbe", 32'(wb_e_), 32'd0);
        chk("t4.rd", 32'(wb_rd), 32'd20);
        chk("t4.data", wb_data, 32'hC20);
        chk("t4.count0", 32'(count), 32'd0);
        chk("t4.req", 32'(wb_req_), 32'd1);
        tick();
        chk("t4.wbe_idle", 32'(wb_e_), 32'd1);
        chk("t4.count_idle", 32'(count), 32'd0);

        // Exception passthrough
        wb_ack_ = 1'b0;
        push(5'd7, 32'h55, 1'b0, MISS);
        tick();
        push(5'd8, 32'h66, 1'b0, 4'h5);
        tick();
        idle();
`ifndef WB_BUF_BYPASS_EN
        #1;
        chk("t5.exp_a", 32'(wb_exp_), 32'd0);
        chk("t5.rd_a", 32'(wb_rd), 32'd7);
        chk("t5.code_a", 32'(wb_exp_code), 32'(MISS));
        tick();
        chk("t5.exp_b", 32'(wb_exp_), 32'd0);
        chk("t5.rd_b", 32'(wb_rd), 32'd8);
        chk("t5.code_b", 32'(wb_exp_code), 32'h5);
`else
        #1;
        chk("t5.exp_b", 32'(wb_exp_), 32'd0);
        chk("t5.rd_b", 32'(wb_rd), 32'd8);
        chk("t5.code_b", 32'(wb_exp_code), 32'h5);
`endif
        tick();
        chk_idle_out("t5.idle");
        wb_ack_ = 1'b1;

        // Async reset mid-drain at count=2
        for (int i = 0; i < 3; i++) begin
            push(5'(30 + i), 32'hD30 + 32'(i), 1'b1, 4'h7);
            tick();
        end
        idle();
        wb_ack_ = 1'b0;
        tick();
        chk("t6.wbe", 32'(wb_e_), 32'd0);
        chk("t6.rd", 32'(wb_rd), 32'd30);
        chk("t6.count2", 32'(count), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("t6.count", 32'(count), 32'd0);
        chk("t6.busy", 32'(busy), 32'd0);
        chk("t6.req", 32'(wb_req_), 32'd1);
        chk("t6.pre", 32'(pre_wb_rd), 32'd0);
        chk_idle_out("t6");
        wb_ack_ = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("t6.count_post", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/exe_wb_buf.md
# exe_wb_buf

- Per-execution-unit writeback queue sitting directly upstream of the common data bus arbiter.
- Accepts finished results from one unit (ALU, DIV, FPU, FDIV, CSR or MEM) into a small FIFO and raises the active-low writeback request to the arbiter.
- Presents the head destination register as the pre-writeback tag.
- On grant, pops the head and drives the registered writeback bundle one cycle later.
- Decouples unit completion from arbitration loss, so units do not stall on every lost grant.

## Interface

- DATA, `DataWidth, result data width
- DEPTH, 4, FIFO entries; power of two, ≥ 2

- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- flush_  in  1  active-low synchronous pipeline flush
- in_e_  in  1  active-low result valid from unit
- in_rd  in  RegFile_t  result destination
- in_data  in  DATA  result value
- in_exp_  in  1  active-low exception flag
- in_exp_code  in  ExpCode_t  exception code
- busy  out  1  high when FIFO full; unit must not assert in_e_
- count  out  $clog2(DEPTH)+1  current occupancy
- wb_req_  out  1  active-low writeback request to arbiter
- wb_ack_  in  1  active-low grant from arbiter, same cycle as request
- pre_wb_rd  out  RegFile_t  head destination, valid while wb_req_ low, else 0
- wb_e_  out  1  active-low writeback valid
- wb_rd  out  RegFile_t  writeback destination
- wb_data  out  DATA  writeback value
- wb_exp_  out  1  active-low exception
- wb_exp_code  out  ExpCode_t  exception code

## Operation

- **FIFO:** head/tail pointers of $clog2(DEPTH) bits wrap modulo DEPTH; count is one bit wider.
- **Push:** occurs when in_e_ low and flush_ high; the entry is written at tail.
- **Push while full:** illegal; the bench asserts on it and the RTL leaves state unchanged.
- **Request:** wb_req_ = (count == 0), combinational. pre_wb_rd is the head rd when the FIFO is non-empty, else 0.
- **Pop:** occurs when wb_req_ and wb_ack_ are both low. The head entry is copied into the output register and the head advances.
- **Simultaneous push and pop:** allowed at any occupancy below full and leaves count unchanged. At full, busy blocks the push.
- **busy:** busy = (count == DEPTH), combinational.
- **Output register:** wb_e_ is a one-cycle pulse, low only in the cycle after a pop. When no pop occurred, the outputs return to idle values: wb_e_=1, wb_rd=0, wb_data=0, wb_exp_=1, wb_exp_code=EXP_I_MISS_ALIGN.
- **Flush (flush_ low):**
  - Clears the pointers and count, and drops any push in that cycle.
  - A pop granted in the flush cycle still completes: its writeback appears next cycle, because the arbiter has already broadcast pre_wb_rd.
- **wb_ack_ while wb_req_ high:** ignored.

## Timing

- **Reset values:** count=0, busy=0, wb_req_=1, pre_wb_rd=0; wb_* outputs take the idle values above.
- **Push to request latency:** in_e_ in cycle N gives wb_req_ low in cycle N+1 (without bypass).
- **Grant to writeback latency:** grant in cycle N gives wb_e_ low in cycle N+1 with the popped data.
- **Back-to-back pops:** one entry per cycle while granted every cycle.
- **Reset mid-operation:** asynchronously clears all state. A pending writeback pulse is lost, and wb_e_ goes high immediately.

## Configuration

- **WB_BUF_BYPASS_EN defined:**
  - When count==0 and in_e_ low, wb_req_ goes low in the same cycle and pre_wb_rd=in_rd.
  - If granted, the input goes straight to the output register (wb_e_ low in cycle N+1) and is not written to the FIFO.
  - If not granted, it is pushed normally.
  - flush_ low suppresses the bypass request entirely.
- **Undefined:** every result passes through the FIFO, giving a minimum of 2 cycles from in_e_ to wb_e_.

## Test plan

- **Single result, grant tied low:** push rd=5, data=0x1234 in cycle 0.
  - Without bypass: wb_req_ low in cycle 1, wb_e_ low in cycle 2 with wb_rd=5, wb_data=0x1234.
  - With bypass: wb_req_ low in cycle 0, wb_e_ low in cycle 1.
- **Fill and drain, grant withheld:** push 4 entries with wb_ack_ high.
  - busy=1 and count=4; pre_wb_rd equals the first rd.
  - Release the grant for 4 cycles: 4 consecutive wb_e_ pulses in push order; then count=0, busy=0.
- **Simultaneous push/pop at count=2:** count stays 2; order is preserved across a pointer wrap (push 6 entries total).
- **Flush with grant in the same cycle at count=3:** the head is written back next cycle, and count=0 after the flush.
- **Exception passthrough:** in_exp_=0, in_exp_code=EXP_I_MISS_ALIGN produces wb_exp_=0 with the matching code. Idle cycles show wb_exp_=1.
- **Async reset asserted mid-drain at count=2:** all outputs return to reset values in the same cycle, before the next clock edge.
